id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 20 ++
 rtl/id_ex_stage.sv | 115 +++++++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline widths, MemtoReg encodings and the ID/EX payload record.
package pipeline_pkg;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;
  localparam int M2R_W   = 2;

  localparam logic [M2R_W-1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [M2R_W-1:0] MEMTOREG_MEM = 2'b01;

  typedef struct packed {
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [DATA_W-1:0]  bus_a;
    logic [DATA_W-1:0]  bus_b;
    logic [DATA_W-1:0]  imm;
    logic               regwr;
    logic               memwr;
    logic               memrd;
    logic [M2R_W-1:0]   memtoreg;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
  } id_ex_t;

  // A bubble is an all-zero record: no writes, no memory access, $0 indices.
  function automatic id_ex_t bubble_rec();
    id_ex_t b;
    b          = '0;
    b.memtoreg = MEMTOREG_ALU;
    return b;
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic             memrd_ex_i,
  input  logic [REG_W-1:0] rt_ex_i,
  input  logic [REG_W-1:0] rs_id_i,
  input  logic [REG_W-1:0] rt_id_i,
  input  logic             memwr_id_i,
  output logic             hazard_o
);
  logic rs_dep, rt_dep, store_data_only;

  assign rs_dep = (rt_ex_i == rs_id_i);
  assign rt_dep = (rt_ex_i == rt_id_i);
  // A store that needs the loaded value only as write data gets it from MEM forwarding.
  assign store_data_only = memwr_id_i & rt_dep & ~rs_dep;

  assign hazard_o = memrd_ex_i & (rt_ex_i != '0) & (rs_dep | rt_dep) & ~store_data_only;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock.
// Optional STALL_COUNT_EN adds a saturating 16-bit bubble counter (StallCount).
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   RegisterRs_ID,
  input  logic [REG_W-1:0]   RegisterRt_ID,
  input  logic [REG_W-1:0]   RegisterRd_ID,
  input  logic [DATA_W-1:0]  BusA_ID,
  input  logic [DATA_W-1:0]  BusB_ID,
  input  logic [DATA_W-1:0]  Imm_ID,
  input  logic               RegWr_ID,
  input  logic               MemWr_ID,
  input  logic               MemRd_ID,
  input  logic [M2R_W-1:0]   MemtoReg_ID,
  input  logic               ALUSrc_ID,
  input  logic [ALUOP_W-1:0] ALUOp_ID,
  input  logic               Flush_ID,
  input  logic               Stall_EX,
  output logic [REG_W-1:0]   RegisterRs_ID_EX,
  output logic [REG_W-1:0]   RegisterRt_ID_EX,
  output logic [REG_W-1:0]   RegisterRd_ID_EX,
  output logic [DATA_W-1:0]  BusA_ID_EX,
  output logic [DATA_W-1:0]  BusB_ID_EX,
  output logic [DATA_W-1:0]  Imm_ID_EX,
  output logic               RegWr_ID_EX,
  output logic               MemWr_ID_EX,
  output logic               MemRd_ID_EX,
  output logic [M2R_W-1:0]   MemtoReg_ID_EX,
  output logic               ALUSrc_ID_EX,
  output logic [ALUOP_W-1:0] ALUOp_ID_EX,
`ifdef STALL_COUNT_EN
  output logic [15:0]        StallCount,
`endif
  output logic               PCWr,
  output logic               IFIDWr,
  output logic               Bubble
);
  id_ex_t id_rec, ex_d, ex_q;
  logic   hazard_raw, hazard;

  always_comb begin
    id_rec          = '0;
    id_rec.rs       = RegisterRs_ID;
    id_rec.rt       = RegisterRt_ID;
    id_rec.rd       = RegisterRd_ID;
    id_rec.bus_a    = BusA_ID;
    id_rec.bus_b    = BusB_ID;
    id_rec.imm      = Imm_ID;
    id_rec.regwr    = RegWr_ID;
    id_rec.memwr    = MemWr_ID;
    id_rec.memrd    = MemRd_ID;
    id_rec.memtoreg = MemtoReg_ID;
    id_rec.alusrc   = ALUSrc_ID;
    id_rec.aluop    = ALUOp_ID;
  end

  hazard_detect u_hazard (
    .memrd_ex_i (MemRd_ID_EX),
    .rt_ex_i    (RegisterRt_ID_EX),
    .rs_id_i    (RegisterRs_ID),
    .rt_id_i    (RegisterRt_ID),
    .memwr_id_i (MemWr_ID),
    .hazard_o   (hazard_raw)
  );

  // Under reset the register is about to be cleared, so judge on the cleared state.
  assign hazard = hazard_raw & ~reset;
  assign Bubble = hazard & ~Stall_EX & ~Flush_ID;
  assign PCWr   = ~Stall_EX & ~Bubble;
  assign IFIDWr = PCWr;

  always_comb begin
    ex_d = ex_q;
    if (Stall_EX)              ex_d = ex_q;
    else if (Flush_ID | Bubble) ex_d = bubble_rec();
    else                       ex_d = id_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign RegisterRs_ID_EX = ex_q.rs;
  assign RegisterRt_ID_EX = ex_q.rt;
  assign RegisterRd_ID_EX = ex_q.rd;
  assign BusA_ID_EX       = ex_q.bus_a;
  assign BusB_ID_EX       = ex_q.bus_b;
  assign Imm_ID_EX        = ex_q.imm;
  assign RegWr_ID_EX      = ex_q.regwr;
  assign MemWr_ID_EX      = ex_q.memwr;
  assign MemRd_ID_EX      = ex_q.memrd;
  assign MemtoReg_ID_EX   = ex_q.memtoreg;
  assign ALUSrc_ID_EX     = ex_q.alusrc;
  assign ALUOp_ID_EX      = ex_q.aluop;

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Bubble && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized traffic
// against a behavioural model of the ID/EX register and the load-use rule.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RegisterRs_ID, RegisterRt_ID, RegisterRd_ID;
  logic [31:0] BusA_ID, BusB_ID, Imm_ID;
  logic        RegWr_ID, MemWr_ID, MemRd_ID, ALUSrc_ID;
  logic [1:0]  MemtoReg_ID;
  logic [3:0]  ALUOp_ID;
  logic        Flush_ID, Stall_EX;
  logic [4:0]  RegisterRs_ID_EX, RegisterRt_ID_EX, RegisterRd_ID_EX;
  logic [31:0] BusA_ID_EX, BusB_ID_EX, Imm_ID_EX;
  logic        RegWr_ID_EX, MemWr_ID_EX, MemRd_ID_EX, ALUSrc_ID_EX;
  logic [1:0]  MemtoReg_ID_EX;
  logic [3:0]  ALUOp_ID_EX;
  logic        PCWr, IFIDWr, Bubble;
`ifdef STALL_COUNT_EN
  logic [15:0] StallCount;
  int          m_cnt = 0;
`endif

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .RegisterRs_ID(RegisterRs_ID), .RegisterRt_ID(RegisterRt_ID), .RegisterRd_ID(RegisterRd_ID),
    .BusA_ID(BusA_ID), .BusB_ID(BusB_ID), .Imm_ID(Imm_ID),
    .RegWr_ID(RegWr_ID), .MemWr_ID(MemWr_ID), .MemRd_ID(MemRd_ID),
    .MemtoReg_ID(MemtoReg_ID), .ALUSrc_ID(ALUSrc_ID), .ALUOp_ID(ALUOp_ID),
    .Flush_ID(Flush_ID), .Stall_EX(Stall_EX),
    .RegisterRs_ID_EX(RegisterRs_ID_EX), .RegisterRt_ID_EX(RegisterRt_ID_EX),
    .RegisterRd_ID_EX(RegisterRd_ID_EX), .BusA_ID_EX(BusA_ID_EX), .BusB_ID_EX(BusB_ID_EX),
    .Imm_ID_EX(Imm_ID_EX), .RegWr_ID_EX(RegWr_ID_EX), .MemWr_ID_EX(MemWr_ID_EX),
    .MemRd_ID_EX(MemRd_ID_EX), .MemtoReg_ID_EX(MemtoReg_ID_EX), .ALUSrc_ID_EX(ALUSrc_ID_EX),
    .ALUOp_ID_EX(ALUOp_ID_EX),
`ifdef STALL_COUNT_EN
    .StallCount(StallCount),
`endif
    .PCWr(PCWr), .IFIDWr(IFIDWr), .Bubble(Bubble)
  );

  // Model of the instruction currently held in EX.
  typedef struct {
    int rs, rt, rd;
    logic [31:0] a, b, imm;
    bit regwr, memwr, memrd, alusrc;
    int m2r, aluop;
  } instr_t;

  instr_t m;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t nop_instr();
    instr_t n;
    n = '{rs:0, rt:0, rd:0, a:0, b:0, imm:0, regwr:0, memwr:0, memrd:0, alusrc:0, m2r:0, aluop:0};
    return n;
  endfunction

  function automatic instr_t id_instr();
    instr_t n;
    n = '{rs:RegisterRs_ID, rt:RegisterRt_ID, rd:RegisterRd_ID, a:BusA_ID, b:BusB_ID,
          imm:Imm_ID, regwr:RegWr_ID, memwr:MemWr_ID, memrd:MemRd_ID, alusrc:ALUSrc_ID,
          m2r:MemtoReg_ID, aluop:ALUOp_ID};
    return n;
  endfunction

  // The consumer must wait when it reads the register a load in EX is still fetching,
  // unless the only use is as store data (forwarded later from MEM). $0 never conflicts.
  function automatic bit model_hazard();
    bit reads_as_rs, reads_as_rt;
    if (reset) return 0;
    if (!m.memrd || m.rt == 0) return 0;
    reads_as_rs = (m.rt == int'(RegisterRs_ID));
    reads_as_rt = (m.rt == int'(RegisterRt_ID));
    if (MemWr_ID && reads_as_rt && !reads_as_rs) return 0;
    return reads_as_rs || reads_as_rt;
  endfunction

  function automatic string fmt(instr_t x);
    return $sformatf("rs%0d rt%0d rd%0d a%0h b%0h i%0h w%0d sw%0d lw%0d m2r%0d src%0d op%0d",
      x.rs, x.rt, x.rd, x.a, x.b, x.imm, x.regwr, x.memwr, x.memrd, x.m2r, x.alusrc, x.aluop);
  endfunction

  function automatic instr_t dut_instr();
    instr_t n;
    n = '{rs:RegisterRs_ID_EX, rt:RegisterRt_ID_EX, rd:RegisterRd_ID_EX, a:BusA_ID_EX,
          b:BusB_ID_EX, imm:Imm_ID_EX, regwr:RegWr_ID_EX, memwr:MemWr_ID_EX,
          memrd:MemRd_ID_EX, alusrc:ALUSrc_ID_EX, m2r:MemtoReg_ID_EX, aluop:ALUOp_ID_EX};
    return n;
  endfunction

  task automatic set_instr(int rs, int rt, int rd, bit regwr, bit memwr, bit memrd,
                           int m2r, bit alusrc, int aluop);
    RegisterRs_ID = rs[4:0]; RegisterRt_ID = rt[4:0]; RegisterRd_ID = rd[4:0];
    BusA_ID = $urandom; BusB_ID = $urandom; Imm_ID = $urandom;
    RegWr_ID = regwr; MemWr_ID = memwr; MemRd_ID = memrd;
    MemtoReg_ID = m2r[1:0]; ALUSrc_ID = alusrc; ALUOp_ID = aluop[3:0];
  endtask

  task automatic lw8();
    set_instr(2, 8, 8, 1, 0, 1, 1, 1, 0);
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step(string tag);
    bit bub, wr;
    instr_t d;
    #3;
    bub = model_hazard() && !Stall_EX && !Flush_ID;
    wr  = !Stall_EX && !bub;
    chk({tag, ".bubble"}, Bubble, bub);
    chk({tag, ".pcwr"}, PCWr, wr);
    chk({tag, ".ifidwr"}, IFIDWr, wr);
    @(posedge clk);
    if (reset) m = nop_instr();
    else if (Stall_EX) m = m;
    else if (Flush_ID || bub) m = nop_instr();
    else m = id_instr();
`ifdef STALL_COUNT_EN
    if (reset) m_cnt = 0;
    else if (bub && m_cnt < 65535) m_cnt++;
`endif
    #1;
    d = dut_instr();
    checks++;
    if (d != m) begin
      failures++;
      $display("FAIL %s.ex: got {%s} expected {%s}", tag, fmt(d), fmt(m));
    end
`ifdef STALL_COUNT_EN
    chk({tag, ".cnt"}, StallCount, m_cnt[15:0]);
`endif
  endtask

  initial begin
    m = nop_instr();
    reset = 1; Stall_EX = 0; Flush_ID = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset with stall and flush: cleared regardless, write enables follow Stall_EX.
    Stall_EX = 1; Flush_ID = 1; lw8();
    step("rst_stall");
    Stall_EX = 0; Flush_ID = 0; lw8();
    #2 chk("rst.pcwr_hi", PCWr, 1'b1);
    step("rst");
    chk("rst.clear", {RegWr_ID_EX, MemRd_ID_EX, RegisterRt_ID_EX}, 0);

    // lw $8 then dependent add: one bubble, then the add.
    reset = 0; lw8();
    step("lu.lw");
    set_instr(8, 3, 4, 1, 0, 0, 0, 0, 2);
    #2 chk("lu.bubble", Bubble, 1'b1);
    chk("lu.pcwr", PCWr, 1'b0);
    chk("lu.ifidwr", IFIDWr, 1'b0);
    step("lu.a");
    chk("lu.cleared", {RegWr_ID_EX, MemRd_ID_EX}, 2'b00);
    #2 chk("lu.nobubble", Bubble, 1'b0);
    step("lu.b");
    chk("lu.add_in", {RegisterRs_ID_EX, RegWr_ID_EX}, {5'd8, 1'b1});

    // Store using the loaded value only as data: no stall.
    lw8(); step("st.lw");
    set_instr(9, 8, 0, 0, 1, 0, 0, 1, 0);
    #2 chk("st.bubble", Bubble, 1'b0);
    chk("st.pcwr", PCWr, 1'b1);
    step("st.sw");
    chk("st.rt", {RegisterRt_ID_EX, MemWr_ID_EX}, {5'd8, 1'b1});

    // Load into $0 never conflicts.
    set_instr(1, 0, 0, 1, 0, 1, 1, 1, 0); step("z.lw");
    set_instr(0, 5, 6, 1, 0, 0, 0, 0, 1);
    #2 chk("z.bubble", Bubble, 1'b0);
    step("z.use");

    // EX stall with a pending hazard: hold, then exactly one bubble.
    lw8(); step("sx.lw");
    set_instr(8, 8, 7, 1, 0, 0, 0, 0, 3);
    Stall_EX = 1;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("sx.hold%0d", i));
      chk("sx.held", {MemRd_ID_EX, RegisterRt_ID_EX}, {1'b1, 5'd8});
    end
    Stall_EX = 0;
    #2 chk("sx.bubble", Bubble, 1'b1);
    step("sx.b");
    chk("sx.cleared", MemRd_ID_EX, 1'b0);
    step("sx.use");
    chk("sx.use_in", RegisterRd_ID_EX, 5'd7);

    // Flush overrides the hazard and leaves fetch running.
    lw8(); step("fl.lw");
    set_instr(8, 1, 2, 1, 0, 0, 0, 0, 4);
    Flush_ID = 1;
    #2 chk("fl.bubble", Bubble, 1'b0);
    chk("fl.pcwr", PCWr, 1'b1);
    step("fl");
    chk("fl.cleared", {RegWr_ID_EX, MemRd_ID_EX}, 2'b00);
    Flush_ID = 0;

    // Reset beats stall.
    lw8(); step("rs.lw");
    reset = 1; Stall_EX = 1;
    step("rs");
    chk("rs.zero", {RegisterRt_ID_EX, MemRd_ID_EX, BusA_ID_EX}, 0);
    reset = 0; Stall_EX = 0;

    // Randomized traffic over a small register set to provoke dependencies.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      Stall_EX = ($urandom_range(0, 6) == 0);
      Flush_ID = ($urandom_range(0, 9) == 0);
      set_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
                $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 2,
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15));
      step($sformatf("rnd%0d", n));
    end

`ifdef STALL_COUNT_EN
    // Hold a load of $8 in EX so every edge is a bubble, to reach saturation.
    reset = 1; Stall_EX = 0; Flush_ID = 0; step("cnt.rst");
    reset = 0;
    set_instr(8, 1, 1, 1, 0, 0, 0, 0, 0);
    force dut.MemRd_ID_EX = 1'b1;
    force dut.RegisterRt_ID_EX = 5'd8;
    repeat (70000) @(posedge clk);
    #1 chk("cnt.sat", StallCount, 16'hFFFF);
    release dut.MemRd_ID_EX;
    release dut.RegisterRt_ID_EX;
    reset = 1;
    @(posedge clk); #1 chk("cnt.clr", StallCount, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
